// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU command sequencer: opcodes, FSM encoding and
// the bit layout of the compare result.
package alu_seq_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_CMP = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int CMP_GT = 2;
  localparam int CMP_LT = 1;
  localparam int CMP_EQ = 0;

endpackage

// File: rtl/alu_block.sv
// Combinational ALU: wrapping add/sub, unsigned compare flags, and bitwise AND.
module alu_block
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       s,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (s)
      OP_ADD: y = a + b;
      OP_SUB: y = a - b;
      OP_CMP: begin
        y[CMP_GT] = (a > b);
        y[CMP_LT] = (a < b);
        y[CMP_EQ] = (a == b);
      end
      default: y = a & b;
    endcase
  end

endmodule

// File: rtl/alu_cmd_sequencer_fifo.sv
// Command FIFO with registered storage; a written entry is readable the cycle after.
module cmd_fifo #(
  parameter int W     = 11,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queues {A,B,op} commands, runs each through alu_block, and returns the
// result on a valid/ready stream while keeping a chaining accumulator.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [WIDTH-1:0]         cmd_a,
  input  logic [WIDTH-1:0]         cmd_b,
  input  logic [1:0]               cmd_op,
  input  logic                     cmd_acc,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_result,
  output logic [1:0]               rsp_op,
  output logic [WIDTH-1:0]         acc_value,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int EW = 2 * WIDTH + 3;

  logic [1:0]       state;
  logic [EW-1:0]    head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             load;
  logic             head_acc;
  logic [1:0]       head_op;
  logic [WIDTH-1:0] head_a;
  logic [WIDTH-1:0] head_b;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [1:0]       alu_s;
  logic [WIDTH-1:0] alu_y;

  assign cmd_ready = !fifo_full;
  assign busy      = (state != ST_IDLE) || !fifo_empty;

  assign head_b   = head[WIDTH-1:0];
  assign head_a   = head[2*WIDTH-1:WIDTH];
  assign head_op  = head[2*WIDTH+1:2*WIDTH];
  assign head_acc = head[2*WIDTH+2];

  // A new command starts from IDLE, or back-to-back on the response handshake.
  assign load = !fifo_empty &&
                ((state == ST_IDLE) || ((state == ST_RESP) && rsp_ready));

  cmd_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (cmd_valid && cmd_ready),
    .push_data ({cmd_acc, cmd_op, cmd_a, cmd_b}),
    .pop       (load),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  alu_block #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a (alu_a),
    .b (alu_b),
    .s (alu_s),
    .y (alu_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_s      <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_op     <= '0;
      acc_value  <= '0;
    end else begin
      // Accumulator is already up to date here, so cmd_acc chains on the previous result.
      if (load) begin
        alu_a <= head_acc ? acc_value : head_a;
        alu_b <= head_b;
        alu_s <= head_op;
      end
      case (state)
        ST_IDLE: begin
          if (load) state <= ST_EXEC;
        end
        ST_EXEC: begin
          rsp_result <= alu_y;
          rsp_op     <= alu_s;
          rsp_valid  <= 1'b1;
          if (alu_s != OP_CMP) acc_value <= alu_y;
          state <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= load ? ST_EXEC : ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with an in-order response model.
module tb_alu_cmd_sequencer;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_a = '0;
  logic [3:0] cmd_b = '0;
  logic [1:0] cmd_op = '0;
  logic       cmd_acc = 1'b0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [3:0] rsp_result;
  logic [1:0] rsp_op;
  logic [3:0] acc_value;
  logic       busy;
  logic [2:0] fifo_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_op     (cmd_op),
    .cmd_acc    (cmd_acc),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_op     (rsp_op),
    .acc_value  (acc_value),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_alu(input logic [1:0] op, input int a, input int b);
    int r;
    case (op)
      2'b00:   r = (a + b) % 16;
      2'b01:   r = (a - b + 16) % 16;
      2'b10:   r = (a > b ? 4 : 0) + (a < b ? 2 : 0) + (a == b ? 1 : 0);
      default: r = a & b;
    endcase
    return 4'(r);
  endfunction

  // Model: every accepted command yields one response, in acceptance order.
  typedef struct packed {
    logic [3:0] res;
    logic [1:0] op;
    logic [3:0] acc;
  } exp_t;

  exp_t       q[$];
  logic [3:0] macc = '0;
  logic       pend_cmd = 1'b0;
  logic       pend_hs = 1'b0;
  logic       prev_hold = 1'b0;
  logic       p_acc;
  logic [1:0] p_op;
  logic [3:0] p_a;
  logic [3:0] p_b;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      macc      = '0;
      pend_cmd  = 1'b0;
      pend_hs   = 1'b0;
      prev_hold = 1'b0;
      check("reset_rsp_valid", rsp_valid, 0);
      check("reset_fifo_count", fifo_count, 0);
      check("reset_acc_value", acc_value, 0);
    end else begin
      exp_t e;
      if (pend_hs && q.size() != 0) void'(q.pop_front());
      if (pend_cmd) begin
        e.op  = p_op;
        e.res = model_alu(p_op, p_acc ? int'(macc) : int'(p_a), int'(p_b));
        if (p_op != 2'b10) macc = e.res;
        e.acc = macc;
        q.push_back(e);
      end
      check("busy", busy, (q.size() != 0));
      check("cmd_ready", cmd_ready, (fifo_count != 3'(DEPTH)));
      if (prev_hold) check("rsp_valid_held", rsp_valid, 1);
      if (rsp_valid) begin
        check("rsp_has_expected", (q.size() != 0), 1);
        if (q.size() != 0) begin
          check("rsp_result", rsp_result, q[0].res);
          check("rsp_op", rsp_op, q[0].op);
          check("acc_value", acc_value, q[0].acc);
        end
      end
      pend_cmd  = cmd_valid && cmd_ready;
      p_acc     = cmd_acc;
      p_op      = cmd_op;
      p_a       = cmd_a;
      p_b       = cmd_b;
      pend_hs   = rsp_valid && rsp_ready;
      prev_hold = rsp_valid && !rsp_ready;
    end
  end

  task automatic send(input logic acc, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    logic ok;
    int   n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_acc   = acc;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    do begin
      ok = cmd_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 20);
    check("send_accepted", ok, 1);
    cmd_valid = 1'b0;
  endtask

  // Single command into an idle sequencer with rsp_ready=1.
  task automatic one(input string nm, input logic acc, input logic [1:0] op,
                     input logic [3:0] a, input logic [3:0] b, input logic [3:0] exp);
    send(acc, op, a, b);
    check({nm, "_lat0"}, rsp_valid, 0);
    @(posedge clk); #1;
    check({nm, "_lat1"}, rsp_valid, 0);
    @(posedge clk); #1;
    check({nm, "_lat2_valid"}, rsp_valid, 1);
    check({nm, "_result"}, rsp_result, exp);
    @(posedge clk); #1;
    check({nm, "_done"}, rsp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    int   accepted;
    int   nrsp;
    int   last;

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("init_cmd_ready", cmd_ready, 1);
    check("init_rsp_valid", rsp_valid, 0);
    check("init_rsp_result", rsp_result, 0);
    check("init_rsp_op", rsp_op, 0);
    check("init_busy", busy, 0);
    check("init_acc", acc_value, 0);
    @(posedge clk); #1;

    rsp_ready = 1'b1;
    one("add", 1'b0, 2'b00, 4'd12, 4'd3, 4'd15);
    one("sub", 1'b0, 2'b01, 4'd12, 4'd3, 4'd9);
    one("cmp", 1'b0, 2'b10, 4'd12, 4'd3, 4'b0100);
    one("and", 1'b0, 2'b11, 4'd12, 4'd3, 4'd0);
    check("after_and_acc", acc_value, 0);

    one("acc_add0", 1'b0, 2'b00, 4'd12, 4'd3, 4'd15);
    one("acc_add1", 1'b1, 2'b00, 4'd0, 4'd3, 4'd2);
    one("acc_sub", 1'b1, 2'b01, 4'd0, 4'd5, 4'd13);
    check("chain_acc", acc_value, 13);

    one("cmp_pre", 1'b0, 2'b00, 4'd12, 4'd3, 4'd15);
    one("cmp_acc", 1'b1, 2'b10, 4'd0, 4'd15, 4'b0001);
    check("cmp_keeps_acc", acc_value, 15);

    // Backpressure: 6 offered, FIFO plus the one in flight absorbs 5.
    rsp_ready = 1'b0;
    accepted  = 0;
    for (int i = 0; i < 6; i++) begin
      cmd_valid = 1'b1;
      cmd_acc   = 1'b0;
      cmd_op    = 2'(i);
      cmd_a     = 4'(i + 1);
      cmd_b     = 4'd2;
      ok = cmd_ready;
      @(posedge clk); #1;
      if (ok) accepted++;
    end
    cmd_valid = 1'b0;
    check("bp_accepted", accepted, 5);
    check("bp_cmd_ready", cmd_ready, 0);
    check("bp_fifo_count", fifo_count, 4);
    check("bp_rsp_valid", rsp_valid, 1);
    check("bp_first_result", rsp_result, 3);
    repeat (3) @(posedge clk);
    #1;
    check("bp_hold_valid", rsp_valid, 1);
    check("bp_hold_result", rsp_result, 3);
    check("bp_hold_op", rsp_op, 0);
    rsp_ready = 1'b1;
    nrsp = 0;
    last = -1;
    for (int c = 0; c < 40 && nrsp < 5; c++) begin
      if (rsp_valid) begin
        if (last >= 0) check("bp_spacing", c - last, 2);
        last = c;
        nrsp++;
      end
      @(posedge clk); #1;
    end
    check("bp_responses", nrsp, 5);
    check("bp_drained_count", fifo_count, 0);
    check("bp_final_acc", acc_value, 7);
    @(posedge clk); #1;

    // Reset while the second of three queued commands executes.
    send(1'b0, 2'b00, 4'd9, 4'd4);
    send(1'b0, 2'b01, 4'd7, 4'd1);
    send(1'b0, 2'b11, 4'd15, 4'd6);
    check("mid_rsp_valid", rsp_valid, 1);
    check("mid_rsp_result", rsp_result, 13);
    @(posedge clk); #1;
    check("mid_exec_count", fifo_count, 1);
    check("mid_exec_acc", acc_value, 13);
    rst_n = 1'b0;
    #1;
    check("rst_rsp_valid_now", rsp_valid, 0);
    check("rst_count_now", fifo_count, 0);
    check("rst_acc_now", acc_value, 0);
    check("rst_busy_now", busy, 0);
    check("rst_cmd_ready_now", cmd_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("post_rst_no_rsp", rsp_valid, 0);
    end

    // Idle: rsp_ready toggling without commands.
    for (int i = 0; i < 8; i++) begin
      rsp_ready = i[0];
      @(posedge clk); #1;
      check("idle_rsp_valid", rsp_valid, 0);
      check("idle_busy", busy, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
